// File: rtl/adder_defs.sv
// rtl/adder_defs.sv - shared nibble width and sequencer state encoding
package adder_defs;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // 2'd3 is never entered; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ADD  = ST_ADD,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/parallel_adder.sv
// rtl/parallel_adder.sv - 4-bit combinational adder with carry in/out
module parallel_adder
  import adder_defs::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                carryIn,
  output logic [NIBBLE_W-1:0] sum,
  output logic                carryOut
);

  logic [NIBBLE_W:0] total;

  assign total    = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, carryIn};
  assign sum      = total[NIBBLE_W-1:0];
  assign carryOut = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit add by time-sharing one 4-bit adder
module nibble_serial_adder_ctrl
  import adder_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_t              state, state_nx;
  logic [WIDTH-1:0]    op_a, op_b, partial, partial_nx;
  logic                carry;
  logic [CNT_W-1:0]    cnt;
  logic [NIBBLE_W-1:0] add_sum;
  logic                add_cout;

  parallel_adder u_adder (
    .a        (op_a[NIBBLE_W-1:0]),
    .b        (op_b[NIBBLE_W-1:0]),
    .carryIn  (carry),
    .sum      (add_sum),
    .carryOut (add_cout)
  );

  // Each new nibble enters at the top so after NIBBLES cycles nibble 0 sits at the bottom.
  generate
    if (WIDTH == NIBBLE_W) begin : g_single
      assign partial_nx = add_sum;
    end else begin : g_multi
      assign partial_nx = {add_sum, partial[WIDTH-1:NIBBLE_W]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = S_IDLE;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: state_nx = start ? S_ADD : S_IDLE;
      S_ADD: begin
        busy     = 1'b1;
        state_nx = (cnt == LAST_CNT) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      partial  <= '0;
      sum      <= '0;
      carryOut <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a    <= a;
            op_b    <= b;
            carry   <= carryIn;
            cnt     <= '0;
            partial <= '0;
          end
        end
        S_ADD: begin
          carry   <= add_cout;
          partial <= partial_nx;
          op_a    <= op_a >> NIBBLE_W;
          op_b    <= op_b >> NIBBLE_W;
          // Hold the counter on the last nibble so it never wraps.
          if (cnt == LAST_CNT) begin
            sum      <= partial_nx;
            carryOut <= add_cout;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - randomized self-checking bench for the serial adder
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, carry_out;
  logic [W-1:0] sum;

  int total = 0;
  int bad = 0;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .carryIn  (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryOut (carry_out)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Issue one start pulse and watch until busy falls; reports cycle of done relative to accept.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        output int done_cyc, output int busy_cnt, output int done_cnt);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    done_cyc = -1; busy_cnt = 0; done_cnt = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({busy, done, carry_out, sum} !== {3'b000, {W{1'b0}}}) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b cout=%b sum=%h need 0/0/0/0000", busy, done, carry_out, sum);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int dc, bc, dn;
    logic [W:0] exp;
    exp = ref_add(x, y, c);
    run_op(x, y, c, dc, bc, dn);
    total++;
    if ({carry_out, sum} !== exp) begin
      bad++;
      $display("FAIL %s_result got=%h need=%h", name, {carry_out, sum}, exp);
    end
    total++;
    if (dc != N + 1 || bc != N + 1 || dn != 1) begin
      bad++;
      $display("FAIL %s_timing got done_cyc=%0d busy=%0d dones=%0d need %0d/%0d/1", name, dc, bc, dn, N + 1, N + 1);
    end
  endtask

  task automatic test_basic();
    check_op("basic_1234_4321", 16'h1234, 16'h4321, 1'b0);
    total++;
    if (sum !== 16'h5555 || carry_out !== 1'b0) begin
      bad++;
      $display("FAIL basic_const got=%b/%h need=0/5555", carry_out, sum);
    end
  endtask

  task automatic test_carry_ripple();
    check_op("ripple_ffff_1", 16'hFFFF, 16'h0001, 1'b0);
    check_op("ripple_ffff_ffff_c", 16'hFFFF, 16'hFFFF, 1'b1);
    check_op("cin_only", 16'h0000, 16'h0000, 1'b1);
    total++;
    if (sum !== 16'h0001 || carry_out !== 1'b0) begin
      bad++;
      $display("FAIL cin_only_const got=%b/%h need=0/0001", carry_out, sum);
    end
  endtask

  task automatic test_ignore_start();
    int dn;
    int late_busy;
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dn = 0; late_busy = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      if (done) dn++;
      if (cyc >= N + 2 && busy) late_busy++;
      if (cyc == 2 || cyc == N + 1) begin
        a = 16'h1111; b = 16'h1111; cin = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    total++;
    if (sum !== 16'h0100 || carry_out !== 1'b0) begin
      bad++;
      $display("FAIL ignore_sum got=%b/%h need=0/0100", carry_out, sum);
    end
    total++;
    if (dn != 1 || late_busy != 0) begin
      bad++;
      $display("FAIL ignore_handshake got dones=%0d late_busy=%0d need 1/0", dn, late_busy);
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, carry_out, sum} !== {3'b000, {W{1'b0}}}) begin
      bad++;
      $display("FAIL reset_mid got busy=%b done=%b cout=%b sum=%h need 0/0/0/0000", busy, done, carry_out, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    total++;
    if (dn != 0) begin
      bad++;
      $display("FAIL reset_mid_quiet got active_cycles=%0d need 0", dn);
    end
    check_op("after_reset", 16'h000F, 16'h0001, 1'b0);
    total++;
    if (sum !== 16'h0010) begin
      bad++;
      $display("FAIL after_reset_const got=%h need=0010", sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] expq[$];
    logic [W:0] exp;
    logic [W-1:0] xs[3];
    logic [W-1:0] ys[3];
    logic         cs[3];
    int done_at[$];
    int accepted;
    logic prev_busy;
    for (int i = 0; i < 3; i++) begin
      xs[i] = W'($urandom); ys[i] = W'($urandom); cs[i] = 1'($urandom);
    end
    @(negedge clk);
    a = xs[0]; b = ys[0]; cin = cs[0]; start = 1'b1;
    expq.push_back(ref_add(xs[0], ys[0], cs[0]));
    accepted = 0; prev_busy = 1'b0;
    for (int cyc = 0; cyc < 40 && done_at.size() < 3; cyc++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        accepted++;
        if (accepted < 3) begin
          a = xs[accepted]; b = ys[accepted]; cin = cs[accepted];
          expq.push_back(ref_add(xs[accepted], ys[accepted], cs[accepted]));
        end else begin
          start = 1'b0;
        end
      end
      if (done) begin
        done_at.push_back(cyc);
        exp = (expq.size() > 0) ? expq.pop_front() : '0;
        total++;
        if ({carry_out, sum} !== exp) begin
          bad++;
          $display("FAIL b2b_result%0d got=%h need=%h", done_at.size(), {carry_out, sum}, exp);
        end
      end
      prev_busy = busy;
    end
    start = 1'b0;
    total++;
    if (done_at.size() != 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d need=3", done_at.size());
    end else begin
      total++;
      if (done_at[1] - done_at[0] != N + 2 || done_at[2] - done_at[1] != N + 2) begin
        bad++;
        $display("FAIL b2b_spacing got=%0d,%0d need=%0d", done_at[1] - done_at[0], done_at[2] - done_at[1], N + 2);
      end
    end
    repeat (N + 3) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      check_op("random", W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_ripple();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
